// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory-busy, load-use and taken-branch
// hazards into PC/IF-ID/ID-EX/back-end controls, with saturating stall/flush counters.
//
// state  | meaning
// RUN    | normal issue; evaluates load-use and branch hazards
// LSTALL | multi-cycle load-use stall in progress (lu_cnt cycles left)
// MWAIT  | data memory busy; pipeline frozen, resumes ret_state

module hazard_ctrl #(
  parameter int LU_CYCLES = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             be_freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int LCW = $clog2(LU_CYCLES) + 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MWAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  state_t           eff_state;
  logic [LCW-1:0]   lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;

  assign lu = ex_memread_i && (ex_rd_i != 5'd0) &&
              ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));

  always_comb begin
    state_d        = state_q;
    ret_d          = ret_q;
    lu_cnt_d       = lu_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    pc_write_o     = 1'b1;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    be_freeze_o    = 1'b0;
    // Leaving MWAIT behaves as the saved state within the same cycle
    eff_state      = (state_q == MWAIT) ? ret_q : state_q;

    if (rst_i) begin
      // IF/ID has no reset of its own, so keep it flushed while in reset
      pc_write_o     = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
      state_d        = RUN;
      ret_d          = RUN;
      lu_cnt_d       = '0;
    end else if (mem_busy_i) begin
      pc_write_o    = 1'b0;
      if_id_stall_o = 1'b1;
      be_freeze_o   = 1'b1;
      if (state_q != MWAIT) begin
        ret_d   = state_q;
        state_d = MWAIT;
      end
    end else begin
      state_d = eff_state;
      if (eff_state == LSTALL) begin
        pc_write_o     = 1'b0;
        if_id_stall_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
        lu_cnt_d       = lu_cnt_q - LCW'(1);
        if (lu_cnt_q == LCW'(1)) state_d = RUN;
      end else if (lu) begin
        pc_write_o     = 1'b0;
        if_id_stall_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
        if (LU_CYCLES > 1) begin
          state_d  = LSTALL;
          lu_cnt_d = LCW'(LU_CYCLES - 1);
        end
      end else if (branch_taken_i) begin
        if_id_flush_o = 1'b1;
      end
    end

    if (rst_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (if_id_stall_o && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (if_id_flush_o && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      lu_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      lu_cnt_q    <= lu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that sequences the IF/ID pipeline register and the PC: generates the IF/ID stall and flush, the PC write-enable, the ID/EX bubble and the back-end freeze. Arbitrates three hazard sources: data-memory busy, load-use dependency and taken branch/jump. Because IF/ID has no reset of its own, this block flushes it during reset. It also keeps saturating stall/flush cycle counters for performance debug.

## Interface
Parameters:
- LU_CYCLES, 1, stall cycles inserted per load-use hazard (≥1)
- CNT_W, 16, width of performance counters

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- id_rs_i  in  5  rs field of instruction in ID
- id_rt_i  in  5  rt field of instruction in ID
- id_uses_rt_i  in  1  ID instruction reads rt as a source
- ex_memread_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  destination register of instruction in EX
- branch_taken_i  in  1  branch/jump in ID resolved taken
- mem_busy_i  in  1  data memory access not yet complete
- pc_write_o  out  1  PC load enable
- if_id_stall_o  out  1  hold IF/ID contents
- if_id_flush_o  out  1  zero IF/ID instruction
- id_ex_bubble_o  out  1  insert NOP into ID/EX
- be_freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB
- stall_cnt_o  out  CNT_W  cycles with if_id_stall_o=1
- flush_cnt_o  out  CNT_W  cycles with if_id_flush_o=1

## Operation
- Hazard term lu = ex_memread_i & (ex_rd_i≠0) & (ex_rd_i==id_rs_i | (id_uses_rt_i & ex_rd_i==id_rt_i)).
- States: RUN, LSTALL, MWAIT. Registers: state, ret_state (RUN/LSTALL), lu_cnt (width clog2(LU_CYCLES)+1), the two counters.
- Outputs are combinational from the current state and inputs; the state and counters are registered.
- Priority per cycle: rst_i > mem_busy_i > load-use (lu in RUN, or state LSTALL) > branch_taken_i > normal.
- rst_i=1: pc_write_o=0, if_id_stall_o=0, if_id_flush_o=1, id_ex_bubble_o=1, be_freeze_o=0. Next state is RUN, lu_cnt=0, and both counters are 0.
- mem_busy_i=1 (any state): pc_write_o=0, if_id_stall_o=1, be_freeze_o=1, id_ex_bubble_o=0, if_id_flush_o=0.
  - Entering MWAIT saves the current state (RUN or LSTALL) in ret_state.
  - lu_cnt is frozen.
  - Stay in MWAIT while busy; on busy=0, return to ret_state in the same cycle's evaluation.
- Load-use, no busy:
  - Outputs: pc_write_o=0, if_id_stall_o=1, id_ex_bubble_o=1, if_id_flush_o=0, be_freeze_o=0.
  - In RUN with lu=1: if LU_CYCLES=1, stay in RUN; else go to LSTALL with lu_cnt=LU_CYCLES-1.
  - In LSTALL: decrement lu_cnt; on reaching 0 go to RUN.
  - In LSTALL, lu and branch_taken_i are ignored.
- Branch, RUN, no busy, lu=0: pc_write_o=1, if_id_flush_o=1, if_id_stall_o=0, id_ex_bubble_o=0.
- Normal: pc_write_o=1, all other controls 0.
- Simultaneous lu and branch_taken_i: load-use wins, no flush. The branch re-evaluates after the stall.
- Counters:
  - Increment in non-reset cycles when the corresponding output is 1.
  - Saturate at 2^CNT_W-1; no wrap.

## Timing
- Zero-cycle latency from inputs to control outputs (same cycle); state changes take effect the next edge.
- Load-use costs exactly LU_CYCLES stall cycles, plus any MWAIT cycles inserted in between.
- Taken branch costs exactly 1 flush cycle.
- mem_busy_i freezes for exactly the number of cycles it is high.
- Reset mid-LSTALL or mid-MWAIT: the next cycle is RUN with counters 0, and no residual stall.
- if_id_stall_o and if_id_flush_o are never both 1.
- pc_write_o=0 whenever if_id_stall_o=1.

## Test plan
- Reset: rst_i=1 for 2 cycles → if_id_flush_o=1, pc_write_o=0, counters 0. After release with quiet inputs → pc_write_o=1, all others 0.
- Load-use, LU_CYCLES=1: ex_memread_i=1, ex_rd_i=5, id_rs_i=5 for 1 cycle → 1 cycle of stall+bubble, stall_cnt_o=1.
  - Same with ex_rd_i=0 → no stall.
  - Same with rt match and id_uses_rt_i=0 → no stall.
- LU_CYCLES=3: one load-use hit → stall 3 consecutive cycles, stall_cnt_o=3.
  - mem_busy_i high for 2 cycles during the 2nd stall cycle → 5 stall cycles total; be_freeze_o=1 only for those 2.
- Branch: branch_taken_i=1 for 1 cycle in RUN → if_id_flush_o=1, pc_write_o=1, flush_cnt_o=1.
  - With lu=1 the same cycle → stall, no flush.
- Busy freeze: mem_busy_i=1 for 4 cycles with branch_taken_i=1 → 4 freeze cycles, no flush, then flush on the 5th cycle.
- Saturation and reset: CNT_W=2, 6 stall cycles → stall_cnt_o=3. Assert rst_i in the middle of LSTALL → next cycle RUN, stall_cnt_o=0.
